// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush sequencer for the IF/ID/EX/LS/WB pipeline. It resolves
// load-use hazards and ID-resolved jumps, and freezes the pipe while fetch
// or LS memory is busy. A watchdog on the wait states latches a sticky
// error when a memory port hangs.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1_idx_i,
    input  logic       id_rs1_used_i,
    input  logic [4:0] id_rs2_idx_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] ex_rd_idx_i,
    input  logic       ex_rd_wren_i,
    input  logic       ex_is_load_i,
    input  logic       id_jump_i,
    input  logic       if_valid_i,
    input  logic       ls_req_i,
    input  logic       ls_done_i,
    output logic       pc_stall_o,
    output logic       id_stall_o,
    output logic       ex_stall_o,
    output logic       ls_stall_o,
    output logic       wb_bubble_o,
    output logic       id_flush_o,
    output logic       ex_flush_o,
    output logic       timeout_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LS_WAIT = 2'd1,
        ST_IF_WAIT = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             redirect_pend_q, redirect_pend_d;
    logic             timeout_q, timeout_d;

    logic ls_busy;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic normal_path;

    // A memory op is outstanding and not finishing this cycle.
    assign ls_busy  = ls_req_i & ~ls_done_i;
    assign rs1_hit  = id_rs1_used_i & (id_rs1_idx_i == ex_rd_idx_i);
    assign rs2_hit  = id_rs2_used_i & (id_rs2_idx_i == ex_rd_idx_i);
    assign load_use = ex_is_load_i & ex_rd_wren_i & (ex_rd_idx_i != 5'd0)
                    & (rs1_hit | rs2_hit);

    // Jump and fetch handling only act when nothing of higher priority owns the cycle.
    assign normal_path = (state_q != ST_ERR) & ~ls_busy & ~load_use;

    // State register: FSM, watchdog counter, pending redirect and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            wait_cnt_q      <= '0;
            redirect_pend_q <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            redirect_pend_q <= redirect_pend_d;
            timeout_q       <= timeout_d;
        end
    end

    // Next-state logic: wait-state transitions, watchdog escalation, redirect tracking.
    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        redirect_pend_d = redirect_pend_q;
        timeout_d       = timeout_q;

        case (state_q)
            ST_RUN: begin
                if (ls_busy)
                    state_d = ST_LS_WAIT;
                else if (!if_valid_i)
                    state_d = ST_IF_WAIT;
            end
            ST_LS_WAIT: begin
                if (ls_done_i)
                    state_d = ST_RUN;
            end
            ST_IF_WAIT: begin
                if (ls_busy)
                    state_d = ST_LS_WAIT;
                else if (if_valid_i)
                    state_d = ST_RUN;
            end
            default: state_d = ST_ERR;
        endcase

        if (state_q == ST_LS_WAIT || state_q == ST_IF_WAIT) begin
            if (state_d == ST_RUN) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
                state_d   = ST_ERR;
                timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        if (normal_path) begin
            if (id_jump_i && !if_valid_i)
                redirect_pend_d = 1'b1;
            else if (if_valid_i && redirect_pend_q)
                redirect_pend_d = 1'b0;
        end
    end

    // Output logic: prioritised hold/bubble/flush controls for the stage registers.
    always_comb begin
        pc_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        ex_stall_o  = 1'b0;
        ls_stall_o  = 1'b0;
        wb_bubble_o = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        timeout_o   = timeout_q;
        state_o     = state_q;

        if (!rst_n) begin
            pc_stall_o = 1'b0;
        end else if (state_q == ST_ERR || ls_busy) begin
            pc_stall_o  = 1'b1;
            id_stall_o  = 1'b1;
            ex_stall_o  = 1'b1;
            ls_stall_o  = 1'b1;
            wb_bubble_o = 1'b1;
        end else if (load_use) begin
            pc_stall_o = 1'b1;
            id_stall_o = 1'b1;
            ex_flush_o = 1'b1;
        end else begin
            if (!if_valid_i) begin
                pc_stall_o = 1'b1;
                id_flush_o = 1'b1;
            end
            if (id_jump_i)
                id_flush_o = 1'b1;
            if (if_valid_i && redirect_pend_q)
                id_flush_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed scenarios followed by random traffic, every cycle compared
// against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wren, load, jump, ifv, req, done;

    logic pc_stall, id_stall, ex_stall, ls_stall, wb_bubble, id_flush, ex_flush, timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // model state: 0 running, 1 waiting on LS, 2 waiting on fetch, 3 error
    int m_state;
    int m_waited;
    bit m_pend;
    bit m_tmo;

    pipe_hazard_ctrl #(.CNT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_idx_i(rs1), .id_rs1_used_i(u1),
        .id_rs2_idx_i(rs2), .id_rs2_used_i(u2),
        .ex_rd_idx_i(rd), .ex_rd_wren_i(wren), .ex_is_load_i(load),
        .id_jump_i(jump), .if_valid_i(ifv),
        .ls_req_i(req), .ls_done_i(done),
        .pc_stall_o(pc_stall), .id_stall_o(id_stall), .ex_stall_o(ex_stall),
        .ls_stall_o(ls_stall), .wb_bubble_o(wb_bubble),
        .id_flush_o(id_flush), .ex_flush_o(ex_flush),
        .timeout_o(timeout), .state_o(state)
    );

    always #5 clk = ~clk;

    function automatic bit hazard_now();
        return load && wren && (rd != 5'd0) &&
               ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic logic [9:0] expected_outputs();
        bit busy;
        bit pc, ids, exs, lss, wb, idf, exf;
        busy = req && !done;
        {pc, ids, exs, lss, wb, idf, exf} = 7'b0;
        if (m_state == 3 || busy) begin
            {pc, ids, exs, lss, wb} = 5'b11111;
        end else if (hazard_now()) begin
            pc = 1; ids = 1; exf = 1;
        end else begin
            pc  = !ifv;
            idf = !ifv || jump || (ifv && m_pend);
        end
        return {pc, ids, exs, lss, wb, idf, exf, m_tmo, 2'(m_state)};
    endfunction

    function automatic void model_edge();
        bit busy;
        int nxt;
        if (m_state == 3) return;
        busy = req && !done;
        if (!busy && !hazard_now()) begin
            if (jump && !ifv)      m_pend = 1;
            else if (ifv && m_pend) m_pend = 0;
        end
        case (m_state)
            0:       nxt = busy ? 1 : (!ifv ? 2 : 0);
            1:       nxt = done ? 0 : 1;
            default: nxt = busy ? 1 : (ifv ? 0 : 2);
        endcase
        if (nxt == 0) begin
            m_waited = 0;
        end else if (m_state != 0) begin
            m_waited++;
            if (m_waited >= MAX_WAIT) begin
                nxt   = 3;
                m_tmo = 1;
                m_waited = MAX_WAIT - 1;
            end
        end
        m_state = nxt;
    endfunction

    function automatic logic [9:0] observed();
        return {pc_stall, id_stall, ex_stall, ls_stall, wb_bubble,
                id_flush, ex_flush, timeout, state};
    endfunction

    task automatic check_value(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_value(tag, observed(), expected_outputs());
    endtask

    // Entered at a falling edge; drives one cycle, checks it, advances the model.
    task automatic apply_stimulus(input string tag,
                                  input logic [4:0] a_rs1, input logic a_u1,
                                  input logic [4:0] a_rs2, input logic a_u2,
                                  input logic [4:0] a_rd, input logic a_wren, input logic a_load,
                                  input logic a_jump, input logic a_ifv,
                                  input logic a_req, input logic a_done);
        rs1 = a_rs1; u1 = a_u1; rs2 = a_rs2; u2 = a_u2;
        rd = a_rd; wren = a_wren; load = a_load;
        jump = a_jump; ifv = a_ifv; req = a_req; done = a_done;
        #1;
        check_output(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_value(tag, observed(), 10'b0);
        m_state = 0; m_waited = 0; m_pend = 0; m_tmo = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4:0] r_rs1, r_rs2, r_rd;
        rst_n = 1'b0;
        {rs1, rs2, rd} = 15'b0;
        {u1, u2, wren, load, jump, req, done} = 7'b0;
        ifv = 1'b1;
        m_state = 0; m_waited = 0; m_pend = 0; m_tmo = 0;
        $display("[TB] start");
        @(negedge clk);
        do_reset("reset_state");

        // load-use on rs1, then clean cycle
        apply_stimulus("load_use", 5'd5, 1, 5'd7, 0, 5'd5, 1, 1, 0, 1, 0, 0);
        apply_stimulus("load_use_after", 5'd5, 1, 5'd7, 0, 5'd5, 1, 0, 0, 1, 0, 0);
        // load to x0 with matching rs1 gives nothing
        apply_stimulus("load_x0", 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 0, 1, 0, 0);

        // LS busy three cycles then done
        for (int i = 0; i < 3; i++)
            apply_stimulus("ls_busy", 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 1, 1, 0);
        #1;
        check_value("ls_wait_state", {8'b0, state}, {8'b0, 2'd1});
        apply_stimulus("ls_done", 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 1, 1, 1);
        apply_stimulus("ls_back_run", 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 1, 0, 0);

        // fetch miss with jump, miss, then the stale arrival
        apply_stimulus("if_miss_jump", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0, 0);
        apply_stimulus("if_miss", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 0, 0, 0, 0);
        apply_stimulus("if_stale", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 0, 1, 0, 0);
        apply_stimulus("if_pend_cleared", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 0, 1, 0, 0);

        // load-use hides a jump; jump flushes next cycle
        apply_stimulus("lu_jump", 5'd4, 0, 5'd9, 1, 5'd9, 1, 1, 1, 1, 0, 0);
        apply_stimulus("jump_after_lu", 5'd4, 0, 5'd9, 1, 5'd9, 1, 0, 1, 1, 0, 0);

        // hung LS port escalates to sticky error
        for (int i = 0; i < MAX_WAIT + 2; i++)
            apply_stimulus("hang", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 0, 1, 1, 0);
        #1;
        check_value("err_sticky", {8'b0, timeout, state[1]}, {8'b0, 2'b11});
        apply_stimulus("err_ignores_done", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 1, 1, 1, 1);
        do_reset("err_reset");
        apply_stimulus("post_err_run", 5'd1, 0, 5'd2, 0, 5'd3, 0, 0, 0, 1, 0, 0);

        // random traffic with small register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ((m_state == 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset("rand_reset");
            end else begin
                r_rs1 = 5'($urandom_range(0, 3));
                r_rs2 = 5'($urandom_range(0, 3));
                r_rd  = 5'($urandom_range(0, 3));
                apply_stimulus("random", r_rs1, 1'($urandom), r_rs2, 1'($urandom),
                               r_rd, 1'($urandom), 1'($urandom),
                               ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 3) != 0),
                               ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 1) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
